// File: rtl/fta_bus_pkg.sv
// fta_bus_pkg: FTA command bus types shared by the request arbiter and response buffer.
package fta_bus_pkg;
    localparam int FTA_MAX_OUTSTANDING_PER_CH = 4;
    typedef enum logic [1:0] {OKAY, DECERR, PROTERR, ERR} fta_err_t;
    typedef struct packed {
        logic         cyc;
        logic         we;
        logic [15:0]  sel;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_request128_t;
    typedef struct packed {
        logic         ack;
        fta_err_t     err;
        logic [3:0]   pri;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;
    localparam fta_cmd_response128_t FTA_RESP_IDLE = '{ack: 1'b0, err: OKAY, pri: 4'hF, tid: '0, adr: '0, dat: '0};
endpackage

// File: rtl/fta_req_arbiter_if.sv
// fta_req_arbiter_if: requester, downstream and response-return signals of the request arbiter.
interface fta_req_arbiter_if #(parameter int CHANNELS = 8);
    import fta_bus_pkg::*;
    fta_cmd_request128_t  req_i [CHANNELS];
    logic [CHANNELS-1:0]  stall_o;
    fta_cmd_request128_t  req_o;
    logic                 stall_i;
    fta_cmd_response128_t resp_i;
    fta_cmd_response128_t resp_o [CHANNELS];
    logic                 orphan_o;
    modport slave (input req_i, stall_i, resp_i, output stall_o, req_o, resp_o, orphan_o);
    modport master (output req_i, stall_i, resp_i, input stall_o, req_o, resp_o, orphan_o);
endinterface

// File: rtl/fta_rr_arb.sv
// fta_rr_arb: combinational round-robin pick of the first eligible channel after last.
module fta_rr_arb #(parameter int CHANNELS = 8) (
    input  logic [CHANNELS-1:0]         eligible,
    input  logic [$clog2(CHANNELS)-1:0] last,
    output logic                        valid,
    output logic [$clog2(CHANNELS)-1:0] index
);
    localparam int CW = $clog2(CHANNELS);
    logic [CW-1:0] cand [CHANNELS];
    for (genvar i = 0; i < CHANNELS; i++) begin : g_cand
        assign cand[i] = CW'((int'(last) + i + 1) % CHANNELS);
    end
    // Scan from farthest to nearest so the nearest eligible candidate wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = CHANNELS - 1; k >= 0; k--)
            if (eligible[cand[k]]) begin
                valid = 1'b1;
                index = cand[k];
            end
    end
endmodule

// File: rtl/fta_req_arbiter.sv
// fta_req_arbiter: round-robin sharing of one FTA master port with in-order response routing.
module fta_req_arbiter #(
    parameter int CHANNELS    = 8,
    parameter int OUTSTANDING = 16,
    parameter int MAXCH       = fta_bus_pkg::FTA_MAX_OUTSTANDING_PER_CH
) (
    input logic clk,
    input logic rst,
    fta_req_arbiter_if.slave bus
);
    import fta_bus_pkg::*;
    localparam int CW = $clog2(CHANNELS);
    localparam int PW = $clog2(OUTSTANDING);
    logic [2:0]          credit [CHANNELS];
    logic [CW-1:0]       tags [OUTSTANDING];
    logic [PW-1:0]       wr, rd;
    logic [PW:0]         cnt;
    logic [CW-1:0]       last, g, h;
    logic                gv, slot_free, pop;
    logic [CHANNELS-1:0] elig;
    fta_cmd_response128_t ack_resp;
    assign slot_free = !bus.req_o.cyc || !bus.stall_i;
    assign pop = bus.resp_i.ack && cnt != '0;
    assign h = tags[rd];
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign elig[i] = bus.req_i[i].cyc && credit[i] < 3'(MAXCH) && cnt != (PW+1)'(OUTSTANDING) && slot_free;
        assign bus.stall_o[i] = bus.req_i[i].cyc && !(gv && g == CW'(i));
    end
    fta_rr_arb #(.CHANNELS(CHANNELS)) u_arb (.eligible(elig), .last(last), .valid(gv), .index(g));
    always_comb begin
        ack_resp = bus.resp_i;
        ack_resp.ack = 1'b1;
    end
    always_ff @(posedge clk)
        if (gv) tags[wr] <= g;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.req_o <= '0;
            bus.orphan_o <= 1'b0;
            wr <= '0;
            rd <= '0;
            cnt <= '0;
            last <= CW'(CHANNELS - 1);
            for (int n = 0; n < CHANNELS; n++) begin
                bus.resp_o[n] <= FTA_RESP_IDLE;
                credit[n] <= '0;
            end
        end else begin
            if (slot_free) bus.req_o <= gv ? bus.req_i[g] : '0;
            if (gv) begin
                wr <= wr + PW'(1);
                last <= g;
            end
            if (pop) rd <= rd + PW'(1);
            cnt <= cnt + (PW+1)'(gv) - (PW+1)'(pop);
            bus.orphan_o <= bus.resp_i.ack && cnt == '0;
            for (int n = 0; n < CHANNELS; n++) begin
                bus.resp_o[n] <= (pop && h == CW'(n)) ? ack_resp : FTA_RESP_IDLE;
                credit[n] <= credit[n] + 3'(gv && g == CW'(n)) - 3'(pop && h == CW'(n));
            end
        end
    end
endmodule

// File: tb/tb_fta_req_arbiter.sv
// tb_fta_req_arbiter: directed and random checks of the arbiter against a queue-based model.
module tb_fta_req_arbiter;
    import fta_bus_pkg::*;
    localparam int CH = 8;
    localparam int OS = 16;
    localparam int MX = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fta_req_arbiter_if #(.CHANNELS(CH)) bus();
    fta_req_arbiter #(.CHANNELS(CH), .OUTSTANDING(OS), .MAXCH(MX)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_assert = 0;
    int n_fail = 0;
    fta_cmd_request128_t  m_req;
    fta_cmd_response128_t m_resp [CH];
    logic m_orph;
    int credit [CH];
    int q [$];
    int last;
    int gnt = -1;
    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic reset_model();
        m_req = '0;
        m_orph = 1'b0;
        for (int n = 0; n < CH; n++) begin
            m_resp[n] = FTA_RESP_IDLE;
            credit[n] = 0;
        end
        q.delete();
        last = CH - 1;
    endtask
    task automatic check_outputs();
        chk("req_o", 192'(bus.req_o), 192'(m_req));
        chk("orphan_o", 192'(bus.orphan_o), 192'(m_orph));
        for (int n = 0; n < CH; n++) chk($sformatf("resp_o[%0d]", n), 192'(bus.resp_o[n]), 192'(m_resp[n]));
    endtask
    task automatic set_req(input int n, input bit on);
        fta_cmd_request128_t r;
        r = '0;
        if (on) begin
            r.cyc = 1'b1;
            r.we = 1'($urandom);
            r.sel = 16'($urandom);
            r.tid = 8'(n);
            r.adr = $urandom;
            r.dat = {$urandom, $urandom, $urandom, $urandom};
        end
        bus.req_i[n] = r;
    endtask
    task automatic set_ack(input bit on, input logic [127:0] d);
        fta_cmd_response128_t r;
        r = '0;
        if (on) begin
            r.ack = 1'b1;
            r.err = fta_err_t'($urandom_range(0, 3));
            r.pri = 4'($urandom);
            r.tid = 8'($urandom);
            r.adr = $urandom;
            r.dat = d;
        end
        bus.resp_i = r;
    endtask
    // One clock: check combinational stall against the model, then registered outputs.
    task automatic step();
        int g;
        logic sf;
        logic [CH-1:0] es;
        @(negedge clk);
        sf = !m_req.cyc || !bus.stall_i;
        g = -1;
        if (sf && q.size() < OS)
            for (int k = 1; k <= CH; k++) begin
                int c = (last + k) % CH;
                if (g < 0 && bus.req_i[c].cyc && credit[c] < MX) g = c;
            end
        for (int n = 0; n < CH; n++) es[n] = bus.req_i[n].cyc && g != n;
        chk("stall_o", 192'(bus.stall_o), 192'(es));
        for (int n = 0; n < CH; n++) m_resp[n] = FTA_RESP_IDLE;
        m_orph = 1'b0;
        if (bus.resp_i.ack) begin
            if (q.size() > 0) begin
                int hd = q.pop_front();
                m_resp[hd] = bus.resp_i;
                m_resp[hd].ack = 1'b1;
                credit[hd]--;
            end else m_orph = 1'b1;
        end
        if (sf) m_req = (g >= 0) ? bus.req_i[g] : '0;
        if (g >= 0) begin
            q.push_back(g);
            credit[g]++;
            last = g;
        end
        gnt = g;
        @(posedge clk);
        #1;
        check_outputs();
    endtask
    task automatic drain();
        for (int n = 0; n < CH; n++) set_req(n, 1'b0);
        bus.stall_i = 1'b0;
        while (q.size() > 0) begin
            set_ack(1'b1, {$urandom, $urandom, $urandom, $urandom});
            step();
        end
        set_ack(1'b0, '0);
        step();
    endtask
    initial begin
        int ord [6] = '{0, 3, 5, 0, 3, 5};
        logic [127:0] dv [3] = '{128'hA, 128'hB, 128'hC};
        int dst [3] = '{1, 4, 1};
        logic [CH-1:0] acks;
        for (int n = 0; n < CH; n++) set_req(n, 1'b0);
        bus.stall_i = 1'b0;
        set_ack(1'b0, '0);
        reset_model();
        #12;
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 1'b1);
        set_req(3, 1'b1);
        set_req(5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_order", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'(ord[i])}));
            if (gnt >= 0) set_req(gnt, 1'b1);
        end
        drain();
        set_req(2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) begin
                chk("credit_fill", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'd2}));
                set_req(2, 1'b1);
            end else chk("credit_limit", 192'(bus.req_o.cyc), 192'(1'b0));
        end
        set_ack(1'b1, 128'h5);
        step();
        chk("ack_cycle_no_grant", 192'(bus.req_o.cyc), 192'(1'b0));
        set_ack(1'b0, '0);
        step();
        chk("grant_after_ack", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'd2}));
        drain();
        set_req(6, 1'b1);
        set_req(7, 1'b1);
        step();
        chk("pre_stall", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'd6}));
        set_req(6, 1'b1);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'd6}));
        end
        bus.stall_i = 1'b0;
        step();
        chk("after_stall", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'd7}));
        drain();
        for (int i = 0; i < 3; i++) begin
            set_req(dst[i], 1'b1);
            step();
            chk("issue_order", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'(dst[i])}));
            set_req(dst[i], 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            set_ack(1'b1, dv[i]);
            step();
            chk("inorder_resp", 192'({bus.resp_o[dst[i]].ack, bus.resp_o[dst[i]].dat}), 192'({1'b1, dv[i]}));
        end
        set_ack(1'b1, 128'hE);
        step();
        for (int n = 0; n < CH; n++) acks[n] = bus.resp_o[n].ack;
        chk("orphan_pulse", 192'({bus.orphan_o, acks}), 192'({1'b1, {CH{1'b0}}}));
        set_ack(1'b0, '0);
        step();
        chk("orphan_clear", 192'(bus.orphan_o), 192'(1'b0));
        for (int t = 0; t < 2000; t++) begin
            bus.stall_i = ($urandom_range(0, 3) == 0);
            set_ack($urandom_range(0, 2) == 0, {$urandom, $urandom, $urandom, $urandom});
            for (int n = 0; n < CH; n++)
                if (!bus.req_i[n].cyc ? ($urandom_range(0, 2) == 0) : (gnt == n))
                    set_req(n, $urandom_range(0, 3) != 0);
            step();
        end
        drain();
        for (int n = 0; n < 3; n++) set_req(n, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            if (gnt >= 0) set_req(gnt, 1'b0);
        end
        #3 rst = 1'b1;
        #1;
        reset_model();
        check_outputs();
        for (int n = 0; n < CH; n++) set_req(n, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 1'b1);
        set_req(5, 1'b1);
        set_ack(1'b1, 128'hD);
        step();
        chk("first_after_reset", 192'({bus.req_o.cyc, bus.req_o.tid}), 192'({1'b1, 8'd0}));
        chk("late_ack_orphan", 192'(bus.orphan_o), 192'(1'b1));
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fta_req_arbiter.md
# fta_req_arbiter

Round-robin request arbiter sharing one downstream FTA master port among CHANNELS requesters, with in-order response return routing. It is the upstream partner of the per-channel 4-deep response buffer. The per-channel outstanding limit is exactly 4, so that buffer can never overflow. The block issues one request per cycle, holds it under downstream stall, and records the granting channel in a tag FIFO so that in-order downstream responses are steered back to their originator.

## Interface
- CHANNELS, 8, number of requesters; 2..16.
- OUTSTANDING, 16, tag FIFO depth, i.e. total in-flight requests; power of 2, at least 4.
- MAXCH, 4, per-channel outstanding limit; 1..4.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_i  in  fta_cmd_request128_t [CHANNELS]  requester commands; valid when .cyc is high.
- stall_o  out  [CHANNELS]  per-channel stall; combinational.
- req_o  out  fta_cmd_request128_t  downstream command, registered.
- stall_i  in  1  downstream stall; req_o is held while high.
- resp_i  in  fta_cmd_response128_t  downstream response; valid on .ack; returns in issue order.
- resp_o  out  fta_cmd_response128_t [CHANNELS]  routed responses, registered.
- orphan_o  out  1  one-cycle pulse: ack received with the tag FIFO empty.

## Operation
- Issue-slot free: `slot_free = !req_o.cyc || !stall_i`.
- Channel n is eligible when all of the following hold:
  - req_i[n].cyc;
  - credit[n] < MAXCH;
  - tag FIFO not full;
  - slot_free.
- Grant: the first eligible channel searching from last+1 upward, wrapping modulo CHANNELS. At most one grant per cycle.
- Accepted channel g:
  - req_o <= req_i[g];
  - tag FIFO push g;
  - credit[g]++;
  - last <= g.
- stall_o[n] = req_i[n].cyc && !(grant valid && g==n). A requester holds its command until it sees stall_o low in a cycle.
- No grant and slot_free: req_o.cyc <= 0, all other req_o fields <= 0.
- stall_i high with req_o.cyc high: req_o holds unchanged, no grant, all active requesters see stall.
- resp_i.ack with FIFO non-empty:
  - h = FIFO head; pop;
  - resp_o[h] <= resp_i with .ack=1;
  - credit[h]--.
- resp_i.ack with FIFO empty: no pop, no credit change, orphan_o pulses, resp_o unaffected.
- Every cycle, each resp_o[n] not being loaded gets .ack=0, .err=OKAY, .pri=4'hF, all other fields 0.
- Same-cycle accept and ack on the same channel: credit unchanged. Same-cycle push and pop: FIFO count unchanged.
- Push on a full FIFO cannot occur, because eligibility excludes it.
- Credits saturate by construction. A decrement at 0 cannot occur for a non-orphan ack.
- Widths:
  - credit: 3 bits.
  - FIFO pointers: $clog2(OUTSTANDING) bits, wrapping.
  - count: $clog2(OUTSTANDING)+1 bits.
  - last: $clog2(CHANNELS) bits.

## Timing
- Reset values:
  - req_o = 0;
  - all resp_o = 0 except .pri=4'hF and .err=OKAY;
  - orphan_o = 0;
  - credits = 0;
  - FIFO empty;
  - last = CHANNELS-1, so channel 0 wins first.
- Request latency: accepted in cycle T, req_o.cyc high from T+1.
- Response latency: resp_i.ack in cycle T, resp_o[h].ack high in T+1 for exactly one cycle per ack.
- Throughput: one request and one response per cycle, concurrently.
- stall_o is combinational from req_i, stall_i and state. Requesters must not feed stall_o back into req_i.cyc combinationally.
- Reset mid-operation discards in-flight tags. Late acks after reset pulse orphan_o.

## Structure
- fta_bus_pkg supplies fta_cmd_request128_t, fta_cmd_response128_t and OKAY.
- Add to fta_bus_pkg: a constant FTA_MAX_OUTSTANDING_PER_CH = 4, shared with the response buffer depth.
- Sub-module fta_rr_arb:
  - parameterized CHANNELS;
  - inputs: eligible vector, last pointer;
  - outputs: grant valid, grant index;
  - purely combinational.
- Tag FIFO and credits are inline registers.

## Test plan
- Channels 0, 3, 5 request continuously, stall_i=0 -> req_o carries 0, 3, 5, 0, 3, 5 on consecutive cycles; stall_o high for the two losers each cycle.
- Channel 2 issues 4 requests with no acks -> 5th request stalled, credit[2]=4. One ack arrives -> the following cycle's grant succeeds.
- stall_i held high 3 cycles with req_o.cyc=1 -> req_o unchanged, no pushes. On release, the next grant goes to last+1.
- Issue order ch1, ch4, ch1, then 3 acks with dat 0xA, 0xB, 0xC -> resp_o[1].dat=0xA, resp_o[4].dat=0xB, resp_o[1].dat=0xC, each one cycle after its ack.
- Ack with FIFO empty -> orphan_o=1 for one cycle, all resp_o[n].ack=0.
- Assert rst while 3 requests are in flight -> all outputs at reset values. After deassert, channel 0 is granted first.
